// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and frame/word geometry.
// Also used by the 32-bit word transmitter.
package uart_pkg;

    localparam int OVERSAMPLE     = 16;
    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick generator: one-cycle tick every
// BAUD_DIVISOR clocks. Shared between the UART receiver and transmitter.
module uart_baud_tick #(
    parameter int BAUD_DIVISOR = 326,
    parameter int DIVISOR_BITS = 9
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    logic [DIVISOR_BITS-1:0] count;

    assign o_tick = (count == DIVISOR_BITS'(BAUD_DIVISOR - 1));

    // Count 0..BAUD_DIVISOR-1 and wrap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count <= '0;
        end else if (o_tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_32b.sv
// 8N1 UART receiver (LSB first) that also packs four consecutive bytes,
// least-significant byte first, into a 32-bit word.
// Optional feature macro UART_RX_WORD_TIMEOUT_EN: drop a partial word after
// TIMEOUT_TICKS oversample ticks of idle line and pulse o_timeout_pulse.
//
// Handshake: there is no back-pressure. Each *_pulse output is high for
// exactly one i_clock cycle, and the matching data output is valid in that
// cycle and holds until the next pulse overwrites it.
module uart_rx_32b
    import uart_pkg::*;
#(
    parameter int BAUD_DIVISOR  = 326,
    parameter int DIVISOR_BITS  = 9,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rx,
    input  logic        i_flush,
    output logic [7:0]  o_data_8b,
    output logic        o_rx_done_8b_pulse,
    output logic [31:0] o_data_32b,
    output logic        o_rx_done_32b_pulse,
    output logic [1:0]  o_byte_index,
    output logic        o_frame_error_pulse,
    output logic        o_timeout_pulse
);

    logic        tick;
    logic        rx_meta, rx_sync;
    logic [1:0]  sync_fill;
    logic        armed;
    rx_state_t   state, state_n;
    logic [3:0]  os_cnt, os_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift, shift_n;
    logic        byte_ok, frame_err;
    logic        timeout_hit;
    logic [23:0] asm_word;

    uart_baud_tick #(
        .BAUD_DIVISOR(BAUD_DIVISOR),
        .DIVISOR_BITS(DIVISOR_BITS)
    ) u_tick (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_tick (tick)
    );

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // After reset, start bits are ignored until the real line (not the
    // reset value still in the synchronizer) has been seen high once.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic: mid-bit sampling on the 8th tick of the start bit,
    // then every 16 ticks for data and stop bits.
    always_comb begin
        state_n   = state;
        os_n      = os_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_sync) begin
                    state_n = START;
                    os_n    = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt == 4'(OVERSAMPLE / 2 - 1)) begin
                        os_n  = '0;
                        bit_n = '0;
                        state_n = rx_sync ? IDLE : DATA;
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                        os_n    = '0;
                        shift_n = {rx_sync, shift[7:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state_n = STOP;
                        end
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt == 4'(OVERSAMPLE - 1)) begin
                        os_n      = '0;
                        state_n   = IDLE;
                        byte_ok   = rx_sync;
                        frame_err = !rx_sync;
                    end else begin
                        os_n = os_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Word packer and output registers. A byte arriving with a flush
    // starts a fresh word as byte 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_data_8b           <= '0;
            o_rx_done_8b_pulse  <= 1'b0;
            o_data_32b          <= '0;
            o_rx_done_32b_pulse <= 1'b0;
            o_byte_index        <= '0;
            o_frame_error_pulse <= 1'b0;
            asm_word            <= '0;
        end else begin
            o_rx_done_8b_pulse  <= 1'b0;
            o_rx_done_32b_pulse <= 1'b0;
            o_frame_error_pulse <= 1'b0;
            if (byte_ok) begin
                o_data_8b          <= shift;
                o_rx_done_8b_pulse <= 1'b1;
                if (i_flush) begin
                    asm_word[7:0] <= shift;
                    o_byte_index  <= 2'd1;
                end else if (o_byte_index == 2'(BYTES_PER_WORD - 1)) begin
                    o_data_32b          <= {shift, asm_word};
                    o_rx_done_32b_pulse <= 1'b1;
                    o_byte_index        <= 2'd0;
                end else begin
                    asm_word[8*o_byte_index +: 8] <= shift;
                    o_byte_index <= o_byte_index + 1'b1;
                end
            end else if (frame_err) begin
                o_frame_error_pulse <= 1'b1;
                o_byte_index        <= 2'd0;
            end else if (timeout_hit || i_flush) begin
                o_byte_index <= 2'd0;
            end
        end
    end

`ifdef UART_RX_WORD_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_BITS-1:0] silence_cnt;
    logic               start_det;

    assign start_det   = (state == IDLE) && (state_n == START);
    assign timeout_hit = (o_byte_index != 2'd0) &&
                         (silence_cnt == TO_BITS'(TIMEOUT_TICKS));

    // Count idle ticks while a partial word is pending.
    always_ff @(posedge i_clock) begin
        if (i_reset || start_det || (o_byte_index == 2'd0)) begin
            silence_cnt <= '0;
        end else if ((state == IDLE) && tick && !timeout_hit) begin
            silence_cnt <= silence_cnt + 1'b1;
        end
    end

    // One-cycle pulse when the partial word is dropped.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_timeout_pulse <= 1'b0;
        end else begin
            o_timeout_pulse <= timeout_hit;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
    assign timeout_hit        = 1'b0;
    assign o_timeout_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_32b.sv
// Directed bench for uart_rx_32b with BAUD_DIVISOR=4 (64 clocks per bit)
// and TIMEOUT_TICKS=64. Honours UART_RX_WORD_TIMEOUT_EN like the design.
module tb_uart_rx_32b;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  data_8b;
    logic        done_8b;
    logic [31:0] data_32b;
    logic        done_32b;
    logic [1:0]  byte_index;
    logic        frame_error;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor records
    logic [7:0]  got8_q[$];
    logic [1:0]  gidx_q[$];
    logic [31:0] got32_q[$];
    int n_coinc = 0;
    int n_ferr  = 0;
    int n_tout  = 0;

    // Expected queues
    logic [7:0]  exp_q[$];
    logic [1:0]  exp_idx_q[$];

    uart_rx_32b #(
        .BAUD_DIVISOR (4),
        .DIVISOR_BITS (9),
        .TIMEOUT_TICKS(64)
    ) dut (
        .i_clock            (clock),
        .i_reset            (reset),
        .i_rx               (rx),
        .i_flush            (flush),
        .o_data_8b          (data_8b),
        .o_rx_done_8b_pulse (done_8b),
        .o_data_32b         (data_32b),
        .o_rx_done_32b_pulse(done_32b),
        .o_byte_index       (byte_index),
        .o_frame_error_pulse(frame_error),
        .o_timeout_pulse    (timeout)
    );

    // Clock
    always #5 clock = ~clock;

    // Monitor on the inactive edge
    always @(negedge clock) begin
        if (done_8b) begin
            got8_q.push_back(data_8b);
            gidx_q.push_back(byte_index);
        end
        if (done_32b) begin
            got32_q.push_back(data_32b);
            if (done_8b) n_coinc++;
        end
        if (frame_error) n_ferr++;
        if (timeout) n_tout++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        got8_q.delete();
        gidx_q.delete();
        got32_q.delete();
        exp_q.delete();
        exp_idx_q.delete();
        n_coinc = 0;
        n_ferr  = 0;
        n_tout  = 0;
    endtask

    // Drive one 8N1 frame; a bad stop bit is held low just past its sample point.
    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        if (good_stop) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clks(40);
            rx = 1'b1;
            wait_clks(BIT_CLKS - 40);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(1);
        n_checks++; if (data_8b !== 8'h00) begin n_fail++; $display("FAIL reset_data_8b got %h want 00", data_8b); end
        n_checks++; if (done_8b !== 1'b0) begin n_fail++; $display("FAIL reset_done_8b got %b want 0", done_8b); end
        n_checks++; if (data_32b !== 32'h0) begin n_fail++; $display("FAIL reset_data_32b got %h want 0", data_32b); end
        n_checks++; if (done_32b !== 1'b0) begin n_fail++; $display("FAIL reset_done_32b got %b want 0", done_32b); end
        n_checks++; if (byte_index !== 2'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", byte_index); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
        wait_clks(20);
    endtask

    task automatic test_word();
        clear_mon();
        exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        exp_idx_q = '{2'd1, 2'd2, 2'd3, 2'd0};
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        wait_clks(20);
        n_checks++; if (got8_q.size() !== 4) begin n_fail++; $display("FAIL word_byte_count got %0d want 4", got8_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got8_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL word_byte%0d got %h want %h", i, got8_q[i], exp_q[i]); end
            n_checks++; if (gidx_q[i] !== exp_idx_q[i]) begin n_fail++; $display("FAIL word_index%0d got %0d want %0d", i, gidx_q[i], exp_idx_q[i]); end
        end
        n_checks++; if (got32_q.size() !== 1) begin n_fail++; $display("FAIL word_count got %0d want 1", got32_q.size()); end
        n_checks++; if (got32_q[0] !== 32'h12345678) begin n_fail++; $display("FAIL word_value got %h want 12345678", got32_q[0]); end
        n_checks++; if (n_coinc !== 1) begin n_fail++; $display("FAIL word_coincident got %0d want 1", n_coinc); end
        n_checks++; if (data_32b !== 32'h12345678) begin n_fail++; $display("FAIL word_hold got %h want 12345678", data_32b); end
    endtask

    task automatic test_glitch();
        clear_mon();
        send_byte(8'h5A, 1'b1);
        wait_clks(10);
        n_checks++; if (byte_index !== 2'd1) begin n_fail++; $display("FAIL glitch_pre_index got %0d want 1", byte_index); end
        clear_mon();
        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(150);
        n_checks++; if (got8_q.size() !== 0) begin n_fail++; $display("FAIL glitch_bytes got %0d want 0", got8_q.size()); end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL glitch_frame_err got %0d want 0", n_ferr); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL glitch_state got %0d want IDLE", dut.state); end
        n_checks++; if (byte_index !== 2'd1) begin n_fail++; $display("FAIL glitch_index got %0d want 1", byte_index); end
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'hAA, 1'b0);
        wait_clks(150);
        n_checks++; if (got8_q.size() !== 1) begin n_fail++; $display("FAIL ferr_byte_count got %0d want 1", got8_q.size()); end
        n_checks++; if (got8_q[0] !== 8'h11) begin n_fail++; $display("FAIL ferr_good_byte got %h want 11", got8_q[0]); end
        n_checks++; if (n_ferr !== 1) begin n_fail++; $display("FAIL ferr_pulses got %0d want 1", n_ferr); end
        n_checks++; if (byte_index !== 2'd0) begin n_fail++; $display("FAIL ferr_index got %0d want 0", byte_index); end
        n_checks++; if (data_8b !== 8'h11) begin n_fail++; $display("FAIL ferr_data_hold got %h want 11", data_8b); end
    endtask

    task automatic test_flush();
        clear_mon();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_clks(10);
        n_checks++; if (byte_index !== 2'd2) begin n_fail++; $display("FAIL flush_pre_index got %0d want 2", byte_index); end
        flush = 1'b1;
        wait_clks(1);
        flush = 1'b0;
        wait_clks(2);
        n_checks++; if (byte_index !== 2'd0) begin n_fail++; $display("FAIL flush_index got %0d want 0", byte_index); end
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        wait_clks(20);
        n_checks++; if (got32_q.size() !== 1) begin n_fail++; $display("FAIL flush_word_count got %0d want 1", got32_q.size()); end
        n_checks++; if (got32_q[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL flush_word got %h want deadbeef", got32_q[0]); end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_byte(8'h99, 1'b1);
        send_byte(8'h88, 1'b1);
        clear_mon();
        rx = 1'b0;
        wait_clks(BIT_CLKS * 4);
        n_checks++; if (dut.state !== DATA) begin n_fail++; $display("FAIL rstmid_pre_state got %0d want DATA", dut.state); end
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        n_checks++; if (byte_index !== 2'd0) begin n_fail++; $display("FAIL rstmid_index got %0d want 0", byte_index); end
        n_checks++; if (data_8b !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_8b got %h want 00", data_8b); end
        n_checks++; if (data_32b !== 32'h0) begin n_fail++; $display("FAIL rstmid_data_32b got %h want 0", data_32b); end
        wait_clks(100);
        rx = 1'b1;
        wait_clks(200);
        n_checks++; if (got8_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_spurious got %0d want 0", got8_q.size()); end
        exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        wait_clks(20);
        n_checks++; if (got8_q.size() !== 4) begin n_fail++; $display("FAIL rstmid_byte_count got %0d want 4", got8_q.size()); end
        n_checks++; if (got32_q[0] !== 32'h11223344) begin n_fail++; $display("FAIL rstmid_word got %h want 11223344", got32_q[0]); end
        n_checks++; if (n_ferr !== 0) begin n_fail++; $display("FAIL rstmid_frame_err got %0d want 0", n_ferr); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'h42, 1'b1);
        wait_clks(20);
        n_checks++; if (byte_index !== 2'd1) begin n_fail++; $display("FAIL timeout_pre_index got %0d want 1", byte_index); end
        wait_clks(300);
`ifdef UART_RX_WORD_TIMEOUT_EN
        n_checks++; if (n_tout !== 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want 1", n_tout); end
        n_checks++; if (byte_index !== 2'd0) begin n_fail++; $display("FAIL timeout_index got %0d want 0", byte_index); end
`else
        n_checks++; if (n_tout !== 0) begin n_fail++; $display("FAIL timeout_pulses got %0d want 0", n_tout); end
        n_checks++; if (byte_index !== 2'd1) begin n_fail++; $display("FAIL timeout_index got %0d want 1", byte_index); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_glitch();
        test_frame_error();
        test_flush();
        test_reset_mid_frame();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_32b.md
Name: uart_rx_32b

Overview:
- Serial UART receiver that packs four received bytes into one 32-bit word.
- It is the receive-side counterpart of the 32-bit word transmitter that feeds the host link.
- Sits between the `i_Rx` pin and the debug unit and bootloader. Those consumers get both the raw byte stream and assembled words (instruction or data words sent by the host).
- Format is 8N1, LSB bit first. Within a word, bytes arrive least-significant byte first.

Parameters:
- `BAUD_DIVISOR`, 326: `i_clock` cycles per 16x oversample tick.
- `DIVISOR_BITS`, 9: width of the tick counter; must satisfy 2^`DIVISOR_BITS` >= `BAUD_DIVISOR`.
- `TIMEOUT_TICKS`, 4096: oversample ticks of silence after which a partial word is dropped (feature macro only).

Ports:
- `i_clock`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_rx`  in  1  serial line, idle high, asynchronous to `i_clock`
- `i_flush`  in  1  single-cycle pulse; discards any partial word
- `o_data_8b`  out  8  last valid byte received
- `o_rx_done_8b_pulse`  out  1  one-cycle pulse; `o_data_8b` is valid
- `o_data_32b`  out  32  last complete word received
- `o_rx_done_32b_pulse`  out  1  one-cycle pulse; `o_data_32b` is valid
- `o_byte_index`  out  2  number of bytes already held in the current partial word
- `o_frame_error_pulse`  out  1  one-cycle pulse; stop bit was sampled low
- `o_timeout_pulse`  out  1  one-cycle pulse; partial word dropped on timeout

Behaviour:
- Clock and reset:
  - Single clock `i_clock`.
  - `i_reset` is synchronous and active-high.
  - Reset mid-frame abandons the frame; the line must return high before the next start bit is accepted.
- Reset values:
  - All outputs 0.
  - Synchronizer flops reset to 1.
  - FSM in IDLE; tick counter, bit counter and byte index all 0.
- Input synchronizer: `i_rx` passes through a 2-flop synchronizer, adding 2 cycles of latency. All sampling uses the synchronized signal.
- Tick generator:
  - Free-running counter 0..`BAUD_DIVISOR`-1.
  - Emits a one-cycle tick when it reaches `BAUD_DIVISOR`-1, then wraps to 0.
- Receive FSM (advances only on ticks, except the IDLE exit):
  - IDLE: on synchronized rx = 0, go to START and clear the oversample count.
  - START: on the 8th tick re-sample the line. If it is 0, go to DATA with the count cleared. If it is 1 (glitch), return to IDLE with no output.
  - DATA: every 16 ticks sample one bit into the shift register, LSB first. After 8 bits go to STOP.
  - STOP: after 16 ticks sample the line.
    - Sampled 1: in the same cycle drive `o_data_8b` and pulse `o_rx_done_8b_pulse`.
    - Sampled 0: pulse `o_frame_error_pulse`, discard the byte, clear the byte index to 0.
    - In both cases return to IDLE.
- Word packing:
  - A valid byte at index k is written to bits [8k+7:8k] of the assembly register, then the index increments.
  - On the byte at k=3, in the same cycle:
    - `o_data_32b` takes the full word, including the byte just received.
    - `o_rx_done_32b_pulse` asserts together with `o_rx_done_8b_pulse`.
    - The index wraps to 0.
  - `o_data_8b` and `o_data_32b` hold their values until overwritten.
- Flush:
  - `i_flush` sets the index to 0 with no pulse.
  - If a valid byte completes in the same cycle as a flush, that byte is stored as byte 0 and the index becomes 1.
  - `i_flush` never affects the serial FSM.
- Stop-bit handling: back-to-back frames are accepted. IDLE can detect a start bit in the cycle immediately after the STOP sample.

Optional Feature:
- Macro: `UART_RX_WORD_TIMEOUT_EN`.
- Defined:
  - A silence counter counts ticks while the index is non-zero and the FSM is in IDLE.
  - It clears on any start-bit detection or whenever the index is 0.
  - When it reaches `TIMEOUT_TICKS`, the index is cleared to 0 and `o_timeout_pulse` pulses for one cycle.
- Not defined: no silence counter is built and `o_timeout_pulse` is tied to 0. `TIMEOUT_TICKS` is unused.

Decomposition:
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - `OVERSAMPLE` = 16, `DATA_BITS` = 8, `BYTES_PER_WORD` = 4.
- One natural sub-module, `uart_baud_tick`: tick generator parameterized by `BAUD_DIVISOR` and `DIVISOR_BITS`. The same module is shared with the transmitter.
- The FSM and word packer stay in this module.

Test Plan (`BAUD_DIVISOR`=4, so 64 clocks per bit):
- Send bytes 0x78, 0x56, 0x34, 0x12 back-to-back:
  - four 8b pulses with `o_data_8b` = 0x78, 0x56, 0x34, 0x12;
  - the 4th coincides with the 32b pulse and `o_data_32b` = 0x12345678;
  - `o_byte_index` steps 1, 2, 3, 0.
- Pull rx low for 20 clocks, then release: no pulses, FSM back in IDLE, index unchanged.
- Send 0xAA with stop bit = 0 after one good byte 0x11: `o_frame_error_pulse` once, no 8b pulse for 0xAA, index 0.
- Send 0x01, 0x02, pulse `i_flush`, then send 0xEF, 0xBE, 0xAD, 0xDE: `o_data_32b` = 0xDEADBEEF.
- Assert `i_reset` in the middle of the DATA state of the 3rd byte, then send 4 clean bytes 0x44, 0x33, 0x22, 0x11: outputs 0 after reset, word = 0x11223344.
- With `UART_RX_WORD_TIMEOUT_EN` and `TIMEOUT_TICKS`=64: send one byte, then idle for more than 256 clocks → `o_timeout_pulse` once, index 0. Without the macro: index stays at 1.
